i2s_tx: RTL

Master-mode I2S transmitter for the user-port audio link: generates BCLK, WS and serial DATA from 16-bit signed stereo samples on clk_sys. It complements the existing I2S receiver, which samples on BCLK rising edges and treats WS=0 as the left word, so a loopback through USER_OUT reproduces the transmitted samples. Samples enter through a one-entry hold register with a valid/ready handshake; an empty hold register at frame start repeats the previous frame and raises an underrun pulse.

---
 rtl/i2s_tx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// Master-mode I2S transmitter: BCLK, WS and DATA from 16-bit stereo pairs behind a one-entry hold register.
// Define I2S_TX_LJ_EN for left-justified framing (no one-bit delay); default is Philips I2S.
`timescale 1ns/1ps
module i2s_tx #(
    parameter int CLK_DIV = 8
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        i2s_bclk,
    output logic        i2s_ws,
    output logic        i2s_data,
    output logic        frame_start,
    output logic        underrun
);
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic [4:0]       r_slot;
    logic             r_ws;
    logic             r_data;
    logic             r_frame_start;
    logic             r_underrun;
    logic             r_hold_full;
    logic [15:0]      r_hold_l;
    logic [15:0]      r_hold_r;
    logic [15:0]      r_sh_l;
    logic [15:0]      r_sh_r;

    logic             w_div_tc;
    logic             w_fall;
    logic             w_load;
    logic             w_accept;
    logic             w_bit;
    logic [4:0]       w_slot_nxt;
    logic [4:0]       w_bit_pos;
    logic [15:0]      w_sh_l_nxt;
    logic [15:0]      w_sh_r_nxt;
    logic [15:0]      w_src_l;
    logic [15:0]      w_src_r;

    assign w_div_tc   = (r_div_cnt == DIV_LAST);
    assign w_fall     = w_div_tc & r_bclk;
    assign w_slot_nxt = r_slot + 5'd1;
    assign w_load     = w_fall & (w_slot_nxt == 5'd0);
    assign w_accept   = in_valid & ~r_hold_full;

`ifdef I2S_TX_LJ_EN
    assign w_bit_pos = w_slot_nxt;
    assign w_src_l   = w_sh_l_nxt;
    assign w_src_r   = w_sh_r_nxt;
`else
    // One-bit delay: slot s carries what left-justified framing puts in slot s-1, so slot 0 still sees the old pair.
    assign w_bit_pos = r_slot;
    assign w_src_l   = r_sh_l;
    assign w_src_r   = r_sh_r;
`endif

    assign w_bit = w_bit_pos[4] ? w_src_r[~w_bit_pos[3:0]] : w_src_l[~w_bit_pos[3:0]];

    always_comb begin
        // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
        w_sh_l_nxt = r_sh_l;
        w_sh_r_nxt = r_sh_r;
        if (w_load && r_hold_full) begin
            w_sh_l_nxt = r_hold_l;
            w_sh_r_nxt = r_hold_r;
        end
    end

    // NOTE: non-blocking assignments so every register here samples the pre-edge values of the others.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_div_cnt     <= '0;
            r_bclk        <= 1'b0;
            r_slot        <= 5'd31;
            r_ws          <= 1'b0;
            r_data        <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_hold_full   <= 1'b0;
            r_sh_l        <= '0;
            r_sh_r        <= '0;
        end else begin
            r_div_cnt <= w_div_tc ? '0 : r_div_cnt + DIV_W'(1);
            if (w_div_tc) begin
                r_bclk <= ~r_bclk;
            end

            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            if (w_fall) begin
                r_slot        <= w_slot_nxt;
                r_ws          <= w_slot_nxt[4];
                r_data        <= w_bit;
                r_frame_start <= w_load;
                r_underrun    <= w_load & ~r_hold_full;
            end

            r_sh_l <= w_sh_l_nxt;
            r_sh_r <= w_sh_r_nxt;

            // A write on the load cycle only happens with the hold empty, so the load never consumes it.
            if (w_accept) begin
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // NOTE: hold data is only read while r_hold_full is set, so it carries no reset.
    always_ff @(posedge clk_sys) begin
        if (w_accept) begin
            r_hold_l <= in_l;
            r_hold_r <= in_r;
        end
    end

    assign in_ready    = ~r_hold_full;
    assign i2s_bclk    = r_bclk;
    assign i2s_ws      = r_ws;
    assign i2s_data    = r_data;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule
